// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving PC, regfile, ALU, extender and DM controls.
// Optional MC_CTRL_IMEM_WAIT_EN adds im_ready and stalls FETCH until instruction memory is valid.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
`ifdef MC_CTRL_IMEM_WAIT_EN
  input  logic        im_ready,
`endif
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [1:0]  rf_dsel,
  output logic        alu_bsel,
  output logic [1:0]  ext_op,
  output logic [1:0]  alu_op,
  output logic        dm_we,
  output logic [2:0]  state,
  output logic        retire,
  output logic        err
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q;
  logic err_q, err_d;
  logic fetch_go, hold_ex;
  logic [5:0] op, fn;
  logic is_r, is_addu, is_subu, is_jr, is_nop, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic illegal, dec_done;
`ifdef MC_CTRL_IMEM_WAIT_EN
  assign fetch_go = im_ready;
`else
  assign fetch_go = 1'b1;
`endif
  assign op      = ir_q[31:26];
  assign fn      = ir_q[5:0];
  assign is_r    = op == 6'b000000;
  assign is_addu = is_r && fn == 6'b100001;
  assign is_subu = is_r && fn == 6'b100011;
  assign is_jr   = is_r && fn == 6'b001000;
  assign is_nop  = is_r && fn == 6'b000000;
  assign is_ori  = op == 6'b001101;
  assign is_lui  = op == 6'b001111;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign is_beq  = op == 6'b000100;
  assign is_j    = op == 6'b000010;
  assign is_jal  = op == 6'b000011;
  assign illegal = !(is_addu || is_subu || is_jr || is_nop || is_ori || is_lui ||
                     is_lw || is_sw || is_beq || is_j || is_jal);
  assign dec_done = is_j || is_jal || is_jr || is_nop || illegal;
  always_comb begin
    state_d  = S_FETCH;
    err_d    = err_q;
    hold_ex  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    rf_we    = 1'b0;
    rf_wsel  = 2'b00;
    rf_dsel  = 2'b00;
    alu_bsel = 1'b0;
    ext_op   = 2'b00;
    alu_op   = 2'b00;
    dm_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we   = fetch_go;
        state_d = fetch_go ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        state_d = dec_done ? S_FETCH : S_EXEC;
        pc_we   = dec_done;
        pc_sel  = is_jr ? 2'b11 : (is_j || is_jal) ? 2'b10 : 2'b00;
        rf_we   = is_jal;
        rf_wsel = is_jal ? 2'b10 : 2'b00;
        rf_dsel = is_jal ? 2'b10 : 2'b00;
        err_d   = err_q || illegal;
      end
      S_EXEC: begin
        hold_ex = 1'b1;
        pc_we   = is_beq;
        pc_sel  = is_beq ? 2'b01 : 2'b00;
        state_d = is_beq ? S_FETCH : (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        hold_ex = 1'b1;
        dm_we   = is_sw;
        pc_we   = is_sw;
        state_d = is_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        hold_ex = 1'b1;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        rf_wsel = is_r ? 2'b01 : 2'b00;
        rf_dsel = is_lw ? 2'b01 : 2'b00;
      end
      default: state_d = S_FETCH;
    endcase
    // ALU/extender setup is asserted in EXEC and held stable through MEM and WB
    if (hold_ex) begin
      alu_bsel = is_ori || is_lui || is_lw || is_sw;
      ext_op   = is_lui ? 2'b10 : (is_lw || is_sw) ? 2'b01 : 2'b00;
      alu_op   = (is_subu || is_beq) ? 2'b01 : (is_ori || is_lui) ? 2'b10 : 2'b00;
    end
    // while reset is low nothing may be strobed, even though FETCH normally asserts ir_we
    if (!reset) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'b00;
      rf_we    = 1'b0;
      rf_wsel  = 2'b00;
      rf_dsel  = 2'b00;
      alu_bsel = 1'b0;
      ext_op   = 2'b00;
      alu_op   = 2'b00;
      dm_we    = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (ir_we) ir_q <= instr;
    end
  end
  assign state  = state_q;
  assign retire = pc_we;
  assign err    = err_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized and directed checks of mc_ctrl against a per-instruction behavioural trace model.
module tb_mc_ctrl;
  localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_NOP = 3, C_ORI = 4, C_LUI = 5;
  localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_J = 9, C_JAL = 10, C_ILL = 11;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] instr = 32'd0;
`ifdef MC_CTRL_IMEM_WAIT_EN
  logic im_ready = 1'b1;
`endif
  logic ir_we, pc_we, rf_we, alu_bsel, dm_we, retire, err;
  logic [1:0] pc_sel, rf_wsel, rf_dsel, ext_op, alu_op;
  logic [2:0] state;
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic err_m = 1'b0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr),
`ifdef MC_CTRL_IMEM_WAIT_EN
    .im_ready(im_ready),
`endif
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .rf_dsel(rf_dsel), .alu_bsel(alu_bsel), .ext_op(ext_op), .alu_op(alu_op),
    .dm_we(dm_we), .state(state), .retire(retire), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] dut_vec();
    return {ir_we, pc_we, pc_sel, rf_we, rf_wsel, rf_dsel, alu_bsel, ext_op, alu_op, dm_we, state, retire};
  endfunction

  function automatic int classify(input logic [31:0] w);
    logic [5:0] o, f;
    o = w[31:26];
    f = w[5:0];
    if (o == 6'd0) return f == 6'h21 ? C_ADDU : f == 6'h23 ? C_SUBU : f == 6'h08 ? C_JR : f == 6'h00 ? C_NOP : C_ILL;
    return o == 6'h0D ? C_ORI : o == 6'h0F ? C_LUI : o == 6'h23 ? C_LW : o == 6'h2B ? C_SW :
           o == 6'h04 ? C_BEQ : o == 6'h02 ? C_J : o == 6'h03 ? C_JAL : C_ILL;
  endfunction

  function automatic logic [31:0] make_instr(input int c);
    logic [31:0] w;
    logic [5:0] bad_op [4];
    bad_op = '{6'h01, 6'h3F, 6'h20, 6'h08};
    w = $urandom;
    case (c)
      C_ADDU: w = {6'd0, w[25:11], 5'd0, 6'h21};
      C_SUBU: w = {6'd0, w[25:11], 5'd0, 6'h23};
      C_JR:   w = {6'd0, w[25:21], 15'd0, 6'h08};
      C_NOP:  w = {6'd0, w[25:6], 6'h00};
      C_ORI:  w = {6'h0D, w[25:0]};
      C_LUI:  w = {6'h0F, w[25:0]};
      C_LW:   w = {6'h23, w[25:0]};
      C_SW:   w = {6'h2B, w[25:0]};
      C_BEQ:  w = {6'h04, w[25:0]};
      C_J:    w = {6'h02, w[25:0]};
      C_JAL:  w = {6'h03, w[25:0]};
      default: w = w[0] ? {bad_op[w[2:1]], w[25:0]} : {6'd0, w[25:6], 6'h20};
    endcase
    return w;
  endfunction

  // expected controls from the spec's per-class rules, given the state the instruction is in
  function automatic logic [18:0] model_vec(input int c, input logic [2:0] s, input logic last);
    logic jl, hold, arith;
    logic [1:0] psel, wsel, dsel, ext, aop;
    jl    = c == C_JAL && last;
    hold  = s >= 3'd2;
    arith = c == C_ADDU || c == C_SUBU;
    psel  = !last ? 2'd0 : c == C_BEQ ? 2'd1 : (c == C_J || c == C_JAL) ? 2'd2 : c == C_JR ? 2'd3 : 2'd0;
    wsel  = jl ? 2'd2 : (s == 3'd4 && arith) ? 2'd1 : 2'd0;
    dsel  = jl ? 2'd2 : (s == 3'd4 && c == C_LW) ? 2'd1 : 2'd0;
    ext   = !hold ? 2'd0 : c == C_LUI ? 2'd2 : (c == C_LW || c == C_SW) ? 2'd1 : 2'd0;
    aop   = !hold ? 2'd0 : (c == C_SUBU || c == C_BEQ) ? 2'd1 : (c == C_ORI || c == C_LUI) ? 2'd2 : 2'd0;
    return {s == 3'd0, last, psel, jl || s == 3'd4, wsel, dsel,
            hold && (c == C_ORI || c == C_LUI || c == C_LW || c == C_SW), ext, aop,
            c == C_SW && s == 3'd3, s, last};
  endfunction

  task automatic run_instr(input string nm, input logic [31:0] w, output int cycles);
    int c, n;
    logic [2:0] st [5];
    logic [18:0] exp_v;
    c = classify(w);
    st[0] = 3'd0;
    st[1] = 3'd1;
    st[2] = 3'd2;
    st[3] = (c == C_LW || c == C_SW) ? 3'd3 : 3'd4;
    st[4] = 3'd4;
    n = (c == C_J || c == C_JAL || c == C_JR || c == C_NOP || c == C_ILL) ? 2 :
        c == C_BEQ ? 3 : c == C_LW ? 5 : 4;
    instr = w;
    for (int k = 0; k < n; k++) begin
      exp_v = model_vec(c, st[k], k == n - 1);
      chk_cnt++;
      if (dut_vec() !== exp_v) $display("FAIL %s %h cyc%0d ctl got %h want %h", nm, w, k, dut_vec(), exp_v);
      else pass_cnt++;
      chk_cnt++;
      if (err !== err_m) $display("FAIL %s %h cyc%0d err got %b want %b", nm, w, k, err, err_m);
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    if (c == C_ILL) err_m = 1'b1;
    cycles = n;
  endtask

  task automatic test_reset();
    int cyc;
    #1;
    chk_cnt++;
    if (dut_vec() !== 19'd0 || err !== 1'b0) $display("FAIL reset_init got %h/%b want 0/0", dut_vec(), err);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    instr = 32'h0022_1821;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (state !== 3'd2) $display("FAIL reset_pre_exec state got %0d want 2", state);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    chk_cnt++;
    if (dut_vec() !== 19'd0 || err !== 1'b0) $display("FAIL reset_async got %h/%b want 0/0", dut_vec(), err);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (dut_vec() !== 19'd0 || rf_we !== 1'b0) $display("FAIL reset_hold got %h want 0", dut_vec());
      else pass_cnt++;
    end
    reset = 1'b1;
    err_m = 1'b0;
    #1;
    run_instr("reset_release_addu", 32'h0022_1821, cyc);
  endtask

  task automatic test_directed();
    int cyc;
    run_instr("addu", 32'h0022_1821, cyc);
    chk_cnt++;
    if (cyc !== 4) $display("FAIL addu_cycles got %0d want 4", cyc);
    else pass_cnt++;
    run_instr("lw", 32'h8C08_0004, cyc);
    run_instr("sw", 32'hAC08_0004, cyc);
    run_instr("beq", 32'h1000_0003, cyc);
    run_instr("jal", 32'h0C00_0C00, cyc);
  endtask

  task automatic test_illegal();
    int cyc;
    run_instr("illegal", 32'hFC00_0000, cyc);
    run_instr("post_ill_ori", 32'h3421_0005, cyc);
    run_instr("post_ill_j", 32'h0800_0010, cyc);
    run_instr("post_ill_lw", 32'h8C08_0004, cyc);
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int cyc;
    for (int i = 0; i < 60; i++) run_instr("rand", make_instr($urandom_range(0, 11)), cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int c_list [12] = '{C_J, C_NOP, C_JR, C_JAL, C_BEQ, C_BEQ, C_LW, C_SW, C_LW, C_SUBU, C_LUI, C_ORI};
    foreach (c_list[i]) run_instr("b2b", make_instr(c_list[i]), cyc);
    chk_cnt++;
    if (state !== 3'd0 || ir_we !== 1'b1) $display("FAIL b2b_end state/ir_we got %0d/%b want 0/1", state, ir_we);
    else pass_cnt++;
  endtask

`ifdef MC_CTRL_IMEM_WAIT_EN
  task automatic test_imem_wait();
    int cyc;
    instr = 32'h3421_0005;
    im_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++;
      if (state !== 3'd0 || ir_we !== 1'b0 || pc_we !== 1'b0) $display("FAIL imem_wait%0d state/ir_we got %0d/%b want 0/0", i, state, ir_we);
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    im_ready = 1'b1;
    #1;
    run_instr("ori_after_wait", 32'h3421_0005, cyc);
    chk_cnt++;
    if (cyc + 3 !== 7) $display("FAIL imem_wait_total got %0d want 7", cyc + 3);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_back_to_back();
`ifdef MC_CTRL_IMEM_WAIT_EN
    test_imem_wait();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
